// File: rtl/pwm_fade_pkg.sv
// Shared types and helpers for the PWM fade controller: FSM state codes,
// duty width, and saturating 9-bit step arithmetic.
package pwm_fade_pkg;

  localparam int DUTY_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RAMP_UP   = 3'd1,
    ST_HOLD_HIGH = 3'd2,
    ST_RAMP_DOWN = 3'd3,
    ST_HOLD_LOW  = 3'd4
  } state_t;

  // Clamped increment; the carry bit keeps a 255+STEP sum from wrapping.
  function automatic logic [DUTY_W-1:0] sat_up(
    input logic [DUTY_W-1:0] val,
    input logic [DUTY_W-1:0] step,
    input logic [DUTY_W-1:0] lim
  );
    logic [DUTY_W:0] sum;
    sum = {1'b0, val} + {1'b0, step};
    return (sum > {1'b0, lim}) ? lim : sum[DUTY_W-1:0];
  endfunction

  // Clamped decrement; compares against lim+step so val-step never underflows.
  function automatic logic [DUTY_W-1:0] sat_down(
    input logic [DUTY_W-1:0] val,
    input logic [DUTY_W-1:0] step,
    input logic [DUTY_W-1:0] lim
  );
    logic [DUTY_W:0] floor_plus;
    floor_plus = {1'b0, lim} + {1'b0, step};
    return ({1'b0, val} < floor_plus) ? lim : val - step;
  endfunction

endpackage

// File: rtl/m_tick_edge.sv
// Synchronous rising-edge detector: pulse is high for the one clk in which
// `in` is high but was low at the previous clk edge.
module m_tick_edge (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic pulse
);

  logic in_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) in_q <= 1'b0;
    else     in_q <= in;
  end

  assign pulse = in & ~in_q;

endmodule

// File: rtl/m_pwm_fade_ctrl.sv
// Duty sequencer for an 8-bit PWM: manual up/down stepping in IDLE and an
// auto fade cycle (ramp up, hold, ramp down, hold) paced by slow-tick edges.
// Build option: define PWM_FADE_OUT_EN to drive `pwm` from an internal counter.
module m_pwm_fade_ctrl
  import pwm_fade_pkg::*;
#(
  parameter logic [DUTY_W-1:0] STEP       = 8'd1,
  parameter logic [DUTY_W-1:0] MAX_DUTY   = 8'd255,
  parameter logic [DUTY_W-1:0] MIN_DUTY   = 8'd0,
  parameter logic [DUTY_W-1:0] HOLD_TICKS = 8'd50
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_in,
  input  logic              start,
  input  logic              stop,
  input  logic              repeat_en,
  input  logic              up,
  input  logic              down,
  output logic [DUTY_W-1:0] duty,
  output logic [2:0]        state,
  output logic              busy,
  output logic              cycle_done,
  output logic              pwm
);

  state_t            state_q, state_d;
  logic [DUTY_W-1:0] duty_d;
  logic [DUTY_W-1:0] hold_q, hold_d;
  logic              done_d;
  logic              step;
  logic              hold_exit;
  logic [DUTY_W-1:0] duty_up, duty_dn;

  m_tick_edge u_tick_edge (
    .clk   (clk),
    .rst   (rst),
    .in    (tick_in),
    .pulse (step)
  );

  assign duty_up = sat_up(duty, STEP, MAX_DUTY);
  assign duty_dn = sat_down(duty, STEP, MIN_DUTY);

  // A zero hold length leaves the hold state on the next clk without a step.
  assign hold_exit = (HOLD_TICKS == '0) ||
                     (step && (({1'b0, hold_q} + 9'd1) == {1'b0, HOLD_TICKS}));

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    duty_d  = duty;
    hold_d  = hold_q;
    done_d  = 1'b0;

    if (stop) begin
      state_d = ST_IDLE;
      hold_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_RAMP_UP;
          end else if (step && up && !down) begin
            duty_d = duty_up;
          end else if (step && down && !up) begin
            duty_d = duty_dn;
          end
        end

        ST_RAMP_UP: begin
          if (step) begin
            duty_d = duty_up;
            if (duty_up == MAX_DUTY) begin
              state_d = ST_HOLD_HIGH;
              hold_d  = '0;
            end
          end
        end

        ST_HOLD_HIGH: begin
          if (hold_exit) begin
            state_d = ST_RAMP_DOWN;
            hold_d  = '0;
          end else if (step) begin
            hold_d = hold_q + 8'd1;
          end
        end

        ST_RAMP_DOWN: begin
          if (step) begin
            duty_d = duty_dn;
            if (duty_dn == MIN_DUTY) begin
              state_d = ST_HOLD_LOW;
              hold_d  = '0;
            end
          end
        end

        ST_HOLD_LOW: begin
          if (hold_exit) begin
            done_d  = 1'b1;
            hold_d  = '0;
            state_d = repeat_en ? ST_RAMP_UP : ST_IDLE;
          end else if (step) begin
            hold_d = hold_q + 8'd1;
          end
        end

        default: begin
          state_d = ST_IDLE;
          hold_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      duty       <= MIN_DUTY;
      hold_q     <= '0;
      cycle_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      duty       <= duty_d;
      hold_q     <= hold_d;
      cycle_done <= done_d;
    end
  end

  assign state = state_q;
  assign busy  = (state_q != ST_IDLE);

`ifdef PWM_FADE_OUT_EN
  logic [DUTY_W-1:0] pwm_cnt;

  // Free-running compare: full duty (255) still leaves one low clk per period.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= '0;
      pwm     <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      pwm     <= (pwm_cnt < duty);
    end
  end
`else
  assign pwm = 1'b0;
`endif

endmodule

// File: doc/m_pwm_fade_ctrl.md
Name: m_pwm_fade_ctrl

Overview:
Sequences the duty value for an 8-bit PWM generator. It supports manual up/down stepping and an automatic fade cycle: ramp up, hold, ramp down, hold. Steps are paced by rising edges of the 10 ms slow clock. It sits between the debounced switches and the PWM/7-segment datapath; the `duty` output drives the PWM compare value.

Parameters:
STEP, 8'd1, duty increment/decrement per step event
MAX_DUTY, 8'd255, upper saturation limit and ramp-up target
MIN_DUTY, 8'd0, lower saturation limit and ramp-down target; MIN_DUTY < MAX_DUTY required
HOLD_TICKS, 8'd50, step events spent in each HOLD state

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
tick_in  in  1  slow square wave (10 ms clock); a rising edge is one step event
start  in  1  level; begins auto cycle from IDLE
stop  in  1  level; aborts to IDLE from any state
repeat_en  in  1  1 = loop the auto cycle, 0 = single cycle
up  in  1  debounced manual increment (IDLE only)
down  in  1  debounced manual decrement (IDLE only)
duty  out  8  current duty value
state  out  3  current FSM state code
busy  out  1  1 whenever state != IDLE
cycle_done  out  1  one-clk pulse at the end of HOLD_LOW
pwm  out  1  PWM output (see Optional Feature)

Behaviour:
- Reset (rst=1 at a clk edge): duty=MIN_DUTY, state=IDLE, busy=0, cycle_done=0, hold counter=0, tick history register=0.
- Step event: tick_q <= tick_in each clk; step = tick_in & ~tick_q; one clk wide; latency is one clk from the tick_in rise.
- All arithmetic is done at 9 bits. Up: duty = min(duty+STEP, MAX_DUTY). Down: duty = max(duty-STEP, MIN_DUTY). duty never wraps.
- Priority per clk: rst > stop > start > step-driven action.
- IDLE:
  - On step with up=1, down=0: saturating up.
  - On step with down=1, up=0: saturating down.
  - up=down=1: hold.
  - start=1 and stop=0: -> RAMP_UP next clk; duty unchanged.
- RAMP_UP: on each step, saturating up. When the new duty == MAX_DUTY: -> HOLD_HIGH and clear the hold counter. up/down are ignored.
- HOLD_HIGH: on each step, increment the hold counter. When the count reaches HOLD_TICKS: -> RAMP_DOWN. If HOLD_TICKS=0, leave on the next clk without waiting for a step.
- RAMP_DOWN: mirror of RAMP_UP, saturating down. When the new duty == MIN_DUTY: -> HOLD_LOW and clear the hold counter.
- HOLD_LOW: same as HOLD_HIGH. On exit, cycle_done=1 for one clk, then -> RAMP_UP if repeat_en=1, else -> IDLE.
- stop=1 in any state: -> IDLE next clk.
  - duty retained; hold counter cleared; no cycle_done.
  - start and stop asserted together: stop wins.
- start held high while in a non-IDLE state: ignored. start still high on return to IDLE: restarts the auto cycle (level-sensitive).
- Entering RAMP_UP with duty already == MAX_DUTY: -> HOLD_HIGH on the first step event.
- repeat_en is sampled only at HOLD_LOW exit.
- Outputs are registered, except busy, which is decoded from state.

Optional Feature:
Macro: PWM_FADE_OUT_EN.
- Defined: instantiate an internal free-running 8-bit counter (resets to 0); pwm = (cnt < duty). Full duty (255) gives 255/256 high.
- Undefined: no counter is built and pwm is tied to 0. The port remains present in both builds.

Decomposition:
- Package pwm_fade_pkg holds:
  - state codes ST_IDLE=3'd0, ST_RAMP_UP=3'd1, ST_HOLD_HIGH=3'd2, ST_RAMP_DOWN=3'd3, ST_HOLD_LOW=3'd4
  - DUTY_W=8
- One sub-module, m_tick_edge (synchronous rising-edge detector: clk, rst, in -> pulse).
- The FSM, saturating arithmetic and hold counter stay in m_pwm_fade_ctrl.

Test Plan:
1. Reset, then up=1 with 3 tick_in rises -> duty=3, state=0, busy=0. Then down=1 with 5 rises -> duty=0, with no wrap to 255.
2. STEP=64, manual up with 5 rises -> duty sequence 64, 128, 192, 255, 255 (saturates at MAX_DUTY).
3. HOLD_TICKS=2, STEP=128, repeat_en=0, pulse start:
   - states 1->2 at duty=255, 2->3 after 2 steps, then 3->4 at duty=0;
   - cycle_done pulses once after 2 more steps, then state=0.
4. repeat_en=1, same setup -> after cycle_done, state=1 on the next clk and a second ramp begins.
5. Mid-RAMP_UP at duty=128, assert stop and start together -> state=0 next clk, duty=128, no cycle_done pulse.
6. Assert rst during HOLD_HIGH -> next clk: duty=0, state=0, cycle_done=0. With PWM_FADE_OUT_EN and duty=64 -> pwm high for exactly 64 of 256 clks.
